// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU: op encodings, ctrl type, FSM states
// and small op-classification helpers.
package alu_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_PASS_B   = 3'b000;
    localparam alu_ctrl_t ALU_ADD      = 3'b010;
    localparam alu_ctrl_t ALU_SUBTRACT = 3'b011;
    localparam alu_ctrl_t ALU_AND      = 3'b100;
    localparam alu_ctrl_t ALU_OR       = 3'b101;
    localparam alu_ctrl_t ALU_XOR      = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } alu_ser_state_t;

    // Ops that chain a carry between nibbles and produce C/V flags.
    function automatic logic is_arith(alu_ctrl_t op);
        return (op == ALU_ADD) || (op == ALU_SUBTRACT);
    endfunction

    // Bitwise ops with no inter-nibble dependency.
    function automatic logic is_logic(alu_ctrl_t op);
        return (op == ALU_PASS_B) || (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/alu_nibble_serial_if.sv
// Request/result handshake bundle for alu_nibble_serial.
// master: issue stage / consumer side; slave: the ALU.
interface alu_nibble_serial_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_ctrl_t        ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice. SUB is A + ~B + cin; the caller seeds cin=1
// on the first nibble. Illegal ops give out=0, cout=0.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  alu_ctrl_t  ctrl,
    output logic [3:0] out,
    output logic       cout
);
    logic [3:0] beff;
    logic [4:0] sum;

    // Per-op nibble result and carry-out.
    always_comb begin
        beff = (ctrl == ALU_SUBTRACT) ? ~b : b;
        sum  = {1'b0, a} + {1'b0, beff} + {4'b0000, cin};
        out  = 4'h0;
        cout = 1'b0;
        case (ctrl)
            ALU_PASS_B:            out = b;
            ALU_ADD, ALU_SUBTRACT: begin
                out  = sum[3:0];
                cout = sum[4];
            end
            ALU_AND:               out = a & b;
            ALU_OR:                out = a | b;
            ALU_XOR:               out = a ^ b;
            default:               ;
        endcase
    end
endmodule

// File: rtl/alu_nibble_serial.sv
// Word-wide ALU built from one 4-bit slice, iterated LS nibble first.
// Optional macro ALU_SERIAL_BYPASS_EN: PASS_B/AND/OR/XOR finish in a single
// cycle (IDLE -> DONE); ADD/SUB and illegal ops always take the serial path.
module alu_nibble_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)(
    input  logic               clk,
    input  logic               reset_n,
    alu_nibble_serial_if.slave bus
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned MSB   = WIDTH - 1;

    alu_ser_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;

    logic [IDX_W+1:0] bit_base;
    logic [3:0]       slice_out;
    logic             slice_cout;
    logic             beff_msb;

    assign bit_base = {idx_q, 2'b00};

    alu_nibble_slice u_slice (
        .a    (a_q[bit_base +: 4]),
        .b    (b_q[bit_base +: 4]),
        .cin  (carry_q),
        .ctrl (ctrl_q),
        .out  (slice_out),
        .cout (slice_cout)
    );

`ifdef ALU_SERIAL_BYPASS_EN
    function automatic logic [WIDTH-1:0] word_op(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y,
                                                 alu_ctrl_t op);
        case (op)
            ALU_PASS_B: return y;
            ALU_AND:    return x & y;
            ALU_OR:     return x | y;
            ALU_XOR:    return x ^ y;
            default:    return '0;
        endcase
    endfunction
`endif

    // Next-state: accept in IDLE, one nibble per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        beff_msb = (ctrl_q == ALU_SUBTRACT) ? ~b_q[MSB] : b_q[MSB];

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    ctrl_d   = bus.ctrl;
                    // SUB seeds the +1 of the two's complement through the carry.
                    carry_d  = is_arith(bus.ctrl) ? bus.ctrl[0] : 1'b0;
                    result_d = '0;
                    idx_d    = '0;
                    flag_n_d = 1'b0;
                    flag_z_d = 1'b0;
                    flag_c_d = 1'b0;
                    flag_v_d = 1'b0;
                    state_d  = StRun;
`ifdef ALU_SERIAL_BYPASS_EN
                    if (is_logic(bus.ctrl)) begin
                        result_d = word_op(bus.a, bus.b, bus.ctrl);
                        flag_n_d = result_d[MSB];
                        flag_z_d = (result_d == '0);
                        state_d  = StDone;
                    end
`endif
                end
            end
            StRun: begin
                result_d[bit_base +: 4] = slice_out;
                carry_d                 = slice_cout;
                idx_d                   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIB - 1)) begin
                    flag_n_d = result_d[MSB];
                    flag_z_d = (result_d == '0);
                    if (is_arith(ctrl_q)) begin
                        flag_c_d = slice_cout;
                        flag_v_d = (a_q[MSB] == beff_msb) && (result_d[MSB] != a_q[MSB]);
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= ALU_PASS_B;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    // in_ready depends only on state, so a retired result costs one bubble cycle.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_v    = flag_v_q;
endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed self-checking bench for alu_nibble_serial (WIDTH=32).
// Latency is counted in rising edges, the accepting edge being edge 1.
module tb_alu_nibble_serial;
    import alu_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int          SER_LAT = 9;
`ifdef ALU_SERIAL_BYPASS_EN
    localparam int          LOGIC_LAT = 1;
`else
    localparam int          LOGIC_LAT = 9;
`endif

    typedef struct {
        alu_ctrl_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] exp;  // {result, n, z, c, v}
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_nibble_serial_if #(.WIDTH(WIDTH)) bus ();

    alu_nibble_serial #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Issue one op with out_ready=1; return observed {result,flags} and latency.
    task automatic run_op(input alu_ctrl_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [35:0] got, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.ctrl      = op;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 40);
        got = {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
        @(negedge clk);
    endtask

    task automatic run_table(input vec_t v[$]);
        logic [35:0] got;
        int          lat;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, got, lat);
            total++;
            if (got !== v[i].exp) begin
                bad++;
                $display("FAIL result op=%b a=%h b=%h got=%h want=%h",
                         v[i].op, v[i].a, v[i].b, got, v[i].exp);
            end
            total++;
            if (lat !== v[i].lat) begin
                bad++;
                $display("FAIL latency op=%b got=%0d want=%0d", v[i].op, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ctrl      = ALU_PASS_B;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} !== '0)
        begin
            bad++;
            $display("FAIL reset_outputs got ov=%b res=%h nzcv=%b%b%b%b want all zero",
                     bus.out_valid, bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_arith();
        vec_t v[$];
        v.push_back(vec_t'{ALU_ADD,      32'h0000_000F, 32'h0000_0001, {32'h0000_0010, 4'b0000}, SER_LAT});
        v.push_back(vec_t'{ALU_ADD,      32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 4'b1001}, SER_LAT});
        v.push_back(vec_t'{ALU_ADD,      32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 4'b0110}, SER_LAT});
        v.push_back(vec_t'{ALU_SUBTRACT, 32'h0000_0006, 32'h0000_000A, {32'hFFFF_FFFC, 4'b1000}, SER_LAT});
        v.push_back(vec_t'{ALU_SUBTRACT, 32'h1234_5678, 32'h1234_5678, {32'h0000_0000, 4'b0110}, SER_LAT});
        v.push_back(vec_t'{ALU_SUBTRACT, 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 4'b0011}, SER_LAT});
        run_table(v);
    endtask

    task automatic test_logic();
        vec_t v[$];
        v.push_back(vec_t'{ALU_XOR,    32'hAAAA_AAAA, 32'h5555_5555, {32'hFFFF_FFFF, 4'b1000}, LOGIC_LAT});
        v.push_back(vec_t'{ALU_AND,    32'hF0F0_F0F0, 32'h0FF0_0FF0, {32'h00F0_00F0, 4'b0000}, LOGIC_LAT});
        v.push_back(vec_t'{ALU_OR,     32'h1200_0034, 32'h0045_6700, {32'h1245_6734, 4'b0000}, LOGIC_LAT});
        v.push_back(vec_t'{ALU_PASS_B, 32'h0000_1234, 32'h8000_0001, {32'h8000_0001, 4'b1000}, LOGIC_LAT});
        v.push_back(vec_t'{ALU_PASS_B, 32'hFFFF_FFFF, 32'h0000_0000, {32'h0000_0000, 4'b0100}, LOGIC_LAT});
        run_table(v);
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(vec_t'{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0000, 4'b0100}, SER_LAT});
        v.push_back(vec_t'{3'b001, 32'h0000_0005, 32'h0000_0003, {32'h0000_0000, 4'b0100}, SER_LAT});
        run_table(v);
    endtask

    task automatic test_backpressure();
        int wait_cnt;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 32'h0000_000F;
        bus.b         = 32'h0000_0001;
        bus.ctrl      = ALU_ADD;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Keep a second request pending; it must not be taken until after DONE.
        bus.a = 32'h0000_0001;
        bus.b = 32'h0000_0001;
        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.out_valid, bus.in_ready, bus.result, bus.flag_n, bus.flag_z, bus.flag_c,
                 bus.flag_v} !== {1'b1, 1'b0, 32'h0000_0010, 4'b0000}) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=00000010",
                         i, bus.out_valid, bus.in_ready, bus.result);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL stall_release got ov=%b ir=%b want ov=0 ir=1",
                     bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_accept got in_ready=%b want 0", bus.in_ready);
        end
        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (bus.result !== 32'h0000_0002 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_second got ov=%b res=%h want ov=1 res=00000002",
                     bus.out_valid, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic        seen;
        logic [35:0] got;
        int          lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 32'h0000_0111;
        bus.b         = 32'h0000_0111;
        bus.ctrl      = ALU_ADD;
        bus.out_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.result} !== '0) begin
            bad++;
            $display("FAIL abort_clear got ov=%b res=%h want ov=0 res=00000000",
                     bus.out_valid, bus.result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_pulse got out_valid seen=%b want 0", seen);
        end
        run_op(ALU_ADD, 32'h0000_000F, 32'h0000_0001, got, lat);
        total++;
        if (got !== {32'h0000_0010, 4'b0000} || lat !== SER_LAT) begin
            bad++;
            $display("FAIL abort_recover got res/flags=%h lat=%0d want 000000100 lat=%0d",
                     got, lat, SER_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_nibble_serial.md
Name: alu_nibble_serial

Overview:
- Word-wide ALU that runs one 4-bit ALU slice serially, least-significant nibble first.
- Presents a valid/ready request interface and a valid/ready result interface; takes operands from the issue stage and returns the result word plus NZCV flags.
- Area-cheap execution unit for wide operands, where a full-width carry-lookahead ALU is not justified.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ctrl  input  3  op: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR; 001 and 111 are illegal.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  result word.
- flag_n  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_c  output  1  final carry-out (ADD/SUB only, else 0).
- flag_v  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, nibble index=0, carry=0.
  - result and all flags = 0; out_valid=0; in_ready=1 once reset_n deasserts.
- FSM states IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, ctrl; carry <= ctrl[0] for ADD/SUB, else 0; clear result; idx <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, apply nibble idx of a/b, the carry and ctrl to the slice.
  - Write the slice output into result[4*idx+3:4*idx]; carry <= slice carry-out; idx++.
  - When idx==NIB-1, go to DONE on the same edge.
- SUB semantics: A + ~B + 1, so carry=1 means no borrow.
- Illegal ctrl: nibble output forced to 0, carry forced to 0; full NIB-cycle latency preserved. Result 0, flag_z=1.
- DONE:
  - out_valid=1; result and flags stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready is not combinationally tied to out_ready, so there is one bubble cycle between requests.
- Latency: out_valid rises exactly NIB+1 rising edges after the accepting edge.
- Flags (registered, valid whenever out_valid=1):
  - flag_c = final carry for ADD/SUB.
  - flag_v = (a[MSB] == beff[MSB]) && (result[MSB] != a[MSB]), where beff = ~b for SUB, b for ADD.
- Inputs are ignored while not in IDLE; in_valid may stay high.
- out_ready high in IDLE/RUN has no effect.
- reset_n low in RUN or DONE aborts immediately: the result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro ALU_SERIAL_BYPASS_EN.
- Defined:
  - PASS_B, AND, OR and XOR compute the whole word in one cycle, going IDLE -> DONE directly.
  - Latency is 1 edge after acceptance.
  - ADD/SUB and illegal ops are unchanged.
- Undefined: every op, legal or illegal, takes the serial NIB-cycle path.
- Flag rules are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - the ctrl encodings as localparams (ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR);
  - typedef alu_ctrl_t (logic [2:0]);
  - the FSM state enum alu_ser_state_t.
- One sub-module, alu_nibble_slice: combinational 4-bit op unit.
  - Inputs: a, b, cin, ctrl.
  - Outputs: out, cout.
  - Handles B inversion for SUB internally.
- Top holds the FSM, the index counter, operand/result registers and flag logic.

Test Plan:
- WIDTH=32, ADD a=0x0000_000F, b=0x0000_0001 -> result 0x0000_0010, flags N0 Z0 C0 V0; out_valid exactly 9 edges after acceptance.
- ADD a=0x7FFF_FFFF, b=0x1 -> result 0x8000_0000, N1 V1 C0. SUB a=0x6, b=0xA -> result 0xFFFF_FFFC, N1 C0. SUB a=b=0x1234_5678 -> result 0, Z1 C1.
- XOR a=0xAAAA_AAAA, b=0x5555_5555 -> result 0xFFFF_FFFF, C0 V0. Latency 9 without ALU_SERIAL_BYPASS_EN, 1 with it.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, a new in_valid request is not accepted. Release -> IDLE next edge, request accepted the following edge.
- Assert reset_n=0 mid-RUN (after 3 nibbles) -> out_valid=0, result=0 immediately, no completion pulse. A fresh ADD 0xF+0x1 after release completes correctly.
- ctrl=111 with a=b=0xFFFF_FFFF -> result 0, Z1, C0, V0, latency 9.
